i3c_cmd_launch_ctrl: RTL and testbench

//  Sequences one I3C transfer end to end: takes a 64-bit command descriptor (DWORD0/DWORD1) from the host
//  and switches the reg-file config mux to configuration. It then writes the 8 descriptor bytes to

---
 rtl/i3c_cfg_pkg.sv | 37 +++
 rtl/ctrl_watchdog.sv | 27 ++
 rtl/i3c_cmd_launch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_i3c_cmd_launch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_cfg_pkg.sv
// Types and defaults shared by the I3C command launch path.
package i3c_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL_CFG,
    WRITE,
    SEL_DSN,
    LAUNCH,
    WAIT_DONE,
    COMPLETE
  } launch_state_e;

  // DWORD0 of the command descriptor, MSB first.
  typedef struct packed {
    logic       toc;
    logic       wroc;
    logic       rnw;
    logic [2:0] mode;
    logic [2:0] dtt;
    logic [1:0] rsvd;
    logic [4:0] dev_index;
    logic       cp;
    logic [7:0] cmd;
    logic [3:0] tid;
    logic [2:0] cmd_attr;
  } cmd_desc_t;

  localparam logic [11:0] CONFIG_LOCATION_DEF = 12'd1000;
  localparam int          DESC_BYTES_DEF      = 8;

  // Byte idx of the 64-bit descriptor {DWORD1, DWORD0}; byte 0 is DWORD0[7:0].
  function automatic logic [7:0] desc_byte(input logic [63:0] desc, input logic [2:0] idx);
    return desc[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Cycle watchdog: counts while enabled, synchronous clear, expire is high for
// the single cycle in which the count reaches TIMEOUT_CYCLES-1.
module ctrl_watchdog #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic srst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  assign expire = en && (count_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= expire ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/i3c_cmd_launch_ctrl.sv
// Loads one host descriptor into the reg file through the config path, then
// enables the I3C engine and waits for done or watchdog expiry.
import i3c_cfg_pkg::*;

module i3c_cmd_launch_ctrl #(
  parameter int                    ADDR_WIDTH      = 12,
  parameter logic [ADDR_WIDTH-1:0] CONFIG_LOCATION = CONFIG_LOCATION_DEF,
  parameter int                    DESC_BYTES      = DESC_BYTES_DEF,
  parameter int                    TIMEOUT_CYCLES  = 2_500_000
) (
  input  logic                  i_sdr_clk,
  input  logic                  i_sdr_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [31:0]           i_cmd_dword0,
  input  logic [31:0]           i_cmd_dword1,
  input  logic                  i_engine_done,
  output logic                  o_data_config_mux_sel,
  output logic                  o_regf_wr_en_config,
  output logic [ADDR_WIDTH-1:0] o_regf_wr_address_config,
  output logic [7:0]            o_regf_config,
  output logic                  o_controller_en,
  output logic                  o_busy,
  output logic                  o_cmd_done,
  output logic                  o_cmd_timeout
);

  localparam int CNT_W = $clog2(DESC_BYTES);

  launch_state_e         state_reg;
  cmd_desc_t             pend_dw0_reg;
  logic [31:0]           pend_dw1_reg;
  logic                  pend_valid_reg;
  logic [63:0]           desc_reg;
  logic [CNT_W-1:0]      byte_cnt_reg;
  logic [CNT_W-1:0]      next_cnt;
  logic                  mux_sel_reg;
  logic                  wr_en_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            cfg_reg;
  logic                  ctrl_en_reg;
  logic                  busy_reg;
  logic                  cmd_done_reg;
  logic                  cmd_timeout_reg;
  logic                  accept;
  logic                  consume;
  logic                  wd_expire;

  assign o_cmd_ready = ~pend_valid_reg & ~i_sdr_rst;
  assign accept      = i_cmd_valid & o_cmd_ready;
  assign consume     = pend_valid_reg && (state_reg == IDLE || state_reg == COMPLETE);
  assign next_cnt    = byte_cnt_reg + 1'b1;

  assign o_data_config_mux_sel    = mux_sel_reg;
  assign o_regf_wr_en_config      = wr_en_reg;
  assign o_regf_wr_address_config = addr_reg;
  assign o_regf_config            = cfg_reg;
  assign o_controller_en          = ctrl_en_reg;
  assign o_busy                   = busy_reg;
  assign o_cmd_done               = cmd_done_reg;
  assign o_cmd_timeout            = cmd_timeout_reg;

  ctrl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (i_sdr_clk),
    .srst  (i_sdr_rst),
    .en    (state_reg == WAIT_DONE),
    .clr   (state_reg == LAUNCH),
    .expire(wd_expire)
  );

  // A new accept wins over consumption so a same-edge handoff keeps the new descriptor.
  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst) begin
      pend_valid_reg <= 1'b0;
      pend_dw0_reg   <= '0;
      pend_dw1_reg   <= '0;
    end else if (accept) begin
      pend_valid_reg <= 1'b1;
      pend_dw0_reg   <= cmd_desc_t'(i_cmd_dword0);
      pend_dw1_reg   <= i_cmd_dword1;
    end else if (consume) begin
      pend_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst) begin
      state_reg       <= IDLE;
      desc_reg        <= '0;
      byte_cnt_reg    <= '0;
      mux_sel_reg     <= 1'b0;
      wr_en_reg       <= 1'b0;
      addr_reg        <= CONFIG_LOCATION;
      cfg_reg         <= 8'h00;
      ctrl_en_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      cmd_done_reg    <= 1'b0;
      cmd_timeout_reg <= 1'b0;
    end else begin
      cmd_done_reg    <= 1'b0;
      cmd_timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pend_valid_reg) begin
            state_reg   <= SEL_CFG;
            desc_reg    <= {pend_dw1_reg, pend_dw0_reg};
            mux_sel_reg <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        SEL_CFG: begin
          state_reg    <= WRITE;
          wr_en_reg    <= 1'b1;
          addr_reg     <= CONFIG_LOCATION;
          cfg_reg      <= desc_byte(desc_reg, 3'd0);
          byte_cnt_reg <= '0;
        end
        WRITE: begin
          if (byte_cnt_reg == CNT_W'(DESC_BYTES - 1)) begin
            state_reg   <= SEL_DSN;
            wr_en_reg   <= 1'b0;
            mux_sel_reg <= 1'b0;
          end else begin
            byte_cnt_reg <= next_cnt;
            addr_reg     <= CONFIG_LOCATION + ADDR_WIDTH'(next_cnt);
            cfg_reg      <= desc_byte(desc_reg, 3'(next_cnt));
          end
        end
        SEL_DSN: begin
          state_reg   <= LAUNCH;
          ctrl_en_reg <= 1'b1;
        end
        LAUNCH: begin
          state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Engine done takes priority over a simultaneous watchdog expiry.
          if (i_engine_done || wd_expire) begin
            state_reg       <= COMPLETE;
            ctrl_en_reg     <= 1'b0;
            cmd_done_reg    <= 1'b1;
            cmd_timeout_reg <= ~i_engine_done;
          end
        end
        COMPLETE: begin
          if (pend_valid_reg) begin
            state_reg   <= SEL_CFG;
            desc_reg    <= {pend_dw1_reg, pend_dw0_reg};
            mux_sel_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i3c_cmd_launch_ctrl.sv
// Directed bench: dut_a uses default parameters, dut_b uses a wrapping
// config location and a 16-cycle watchdog.
module tb_i3c_cmd_launch_ctrl;

  localparam logic [7:0]  EXP1 [8] = '{8'h18, 8'h00, 8'h0C, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h04};
  localparam logic [7:0]  EXP2 [8] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h88, 8'h77, 8'h66, 8'h55};
  localparam logic [7:0]  EXP3 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  localparam logic [11:0] WRAP [8] = '{12'd4092, 12'd4093, 12'd4094, 12'd4095, 12'd0, 12'd1, 12'd2, 12'd3};

  logic        clk;
  logic        a_rst, a_valid, a_ready, a_done;
  logic [31:0] a_dw0, a_dw1;
  logic        a_mux, a_wr, a_en, a_busy, a_cdone, a_tmo;
  logic [11:0] a_addr;
  logic [7:0]  a_cfg;
  logic        b_rst, b_valid, b_ready, b_done;
  logic [31:0] b_dw0, b_dw1;
  logic        b_mux, b_wr, b_en, b_busy, b_cdone, b_tmo;
  logic [11:0] b_addr;
  logic [7:0]  b_cfg;

  int checks = 0;
  int errors = 0;

  i3c_cmd_launch_ctrl dut_a (
    .i_sdr_clk(clk), .i_sdr_rst(a_rst), .i_cmd_valid(a_valid), .o_cmd_ready(a_ready),
    .i_cmd_dword0(a_dw0), .i_cmd_dword1(a_dw1), .i_engine_done(a_done),
    .o_data_config_mux_sel(a_mux), .o_regf_wr_en_config(a_wr),
    .o_regf_wr_address_config(a_addr), .o_regf_config(a_cfg),
    .o_controller_en(a_en), .o_busy(a_busy), .o_cmd_done(a_cdone), .o_cmd_timeout(a_tmo)
  );

  i3c_cmd_launch_ctrl #(.CONFIG_LOCATION(12'd4092), .TIMEOUT_CYCLES(16)) dut_b (
    .i_sdr_clk(clk), .i_sdr_rst(b_rst), .i_cmd_valid(b_valid), .o_cmd_ready(b_ready),
    .i_cmd_dword0(b_dw0), .i_cmd_dword1(b_dw1), .i_engine_done(b_done),
    .o_data_config_mux_sel(b_mux), .o_regf_wr_en_config(b_wr),
    .o_regf_wr_address_config(b_addr), .o_regf_config(b_cfg),
    .o_controller_en(b_en), .o_busy(b_busy), .o_cmd_done(b_cdone), .o_cmd_timeout(b_tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout got running exp finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    tick(); tick();
    checks++;
    if ({a_mux, a_wr, a_en, a_busy, a_cdone, a_tmo, a_ready} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b exp %b", {a_mux, a_wr, a_en, a_busy, a_cdone, a_tmo, a_ready}, 7'b0);
    end
    checks++;
    if (a_addr !== 12'd1000 || a_cfg !== 8'h00) begin
      errors++; $display("FAIL reset_addr_data got %0d/%h exp 1000/00", a_addr, a_cfg);
    end
    checks++;
    if (b_addr !== 12'd4092) begin
      errors++; $display("FAIL reset_addr_b got %0d exp 4092", b_addr);
    end
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready got %b exp 11", {a_ready, b_ready});
    end
    $display("reset done");
  endtask

  // Accept a descriptor on dut_a, check the whole write burst and the launch.
  task automatic test_write_burst();
    a_valid = 1'b1; a_dw0 = 32'h0B0C_0018; a_dw1 = 32'h0403_0201;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL burst_ready_idle got %b exp 1", a_ready); end
    tick();  // edge N
    a_valid = 1'b0;
    checks++;
    if (a_ready !== 1'b0 || a_mux !== 1'b0) begin
      errors++; $display("FAIL burst_n0 got ready=%b mux=%b exp 0/0", a_ready, a_mux);
    end
    tick();  // N+1
    checks++;
    if ({a_mux, a_wr, a_en, a_busy, a_ready} !== 5'b10011) begin
      errors++; $display("FAIL burst_selcfg got %b exp 10011", {a_mux, a_wr, a_en, a_busy, a_ready});
    end
    tick();  // N+2
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a_wr !== 1'b1 || a_mux !== 1'b1 || a_en !== 1'b0 || a_addr !== 12'(1000 + k) || a_cfg !== EXP1[k]) begin
        errors++;
        $display("FAIL burst_byte%0d got wr=%b mux=%b en=%b %0d:%h exp 1 1 0 %0d:%h",
                 k, a_wr, a_mux, a_en, a_addr, a_cfg, 1000 + k, EXP1[k]);
      end
      tick();
    end
    checks++;  // N+10
    if ({a_mux, a_wr, a_en} !== 3'b000) begin
      errors++; $display("FAIL burst_seldsn got %b exp 000", {a_mux, a_wr, a_en});
    end
    tick();  // N+11
    checks++;
    if ({a_mux, a_wr, a_en, a_busy} !== 4'b0011) begin
      errors++; $display("FAIL burst_launch got %b exp 0011", {a_mux, a_wr, a_en, a_busy});
    end
    $display("write burst done, controller enabled");
  endtask

  task automatic test_done();
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_en !== 1'b1 || a_cdone !== 1'b0 || a_mux !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL done_wait got ok=%b exp 1", ok); end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++;
    if ({a_en, a_cdone, a_tmo, a_busy} !== 4'b0101) begin
      errors++; $display("FAIL done_complete got %b exp 0101", {a_en, a_cdone, a_tmo, a_busy});
    end
    tick();
    checks++;
    if ({a_en, a_cdone, a_tmo, a_busy} !== 4'b0000) begin
      errors++; $display("FAIL done_idle got %b exp 0000", {a_en, a_cdone, a_tmo, a_busy});
    end
    $display("command 1 done");
  endtask

  task automatic test_back_to_back();
    a_valid = 1'b1; a_dw0 = 32'h0B0C_0018; a_dw1 = 32'h0403_0201;
    tick();
    a_valid = 1'b0;
    repeat (11) tick();
    checks++;
    if (a_en !== 1'b1) begin errors++; $display("FAIL b2b_launch got en=%b exp 1", a_en); end
    a_valid = 1'b1; a_dw0 = 32'hA1B2_C3D4; a_dw1 = 32'h5566_7788;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_wait got %b exp 1", a_ready); end
    tick();
    a_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (a_ready !== 1'b0 || a_en !== 1'b1) begin
      errors++; $display("FAIL b2b_held got ready=%b en=%b exp 0/1", a_ready, a_en);
    end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++;
    if ({a_cdone, a_en, a_ready} !== 3'b100) begin
      errors++; $display("FAIL b2b_complete got %b exp 100", {a_cdone, a_en, a_ready});
    end
    tick();
    checks++;
    if ({a_mux, a_wr, a_cdone, a_busy, a_ready} !== 5'b10011) begin
      errors++; $display("FAIL b2b_selcfg got %b exp 10011", {a_mux, a_wr, a_cdone, a_busy, a_ready});
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a_wr !== 1'b1 || a_addr !== 12'(1000 + k) || a_cfg !== EXP2[k]) begin
        errors++;
        $display("FAIL b2b_byte%0d got wr=%b %0d:%h exp 1 %0d:%h", k, a_wr, a_addr, a_cfg, 1000 + k, EXP2[k]);
      end
      tick();
    end
    tick(); tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++;
    if ({a_cdone, a_tmo} !== 2'b10) begin
      errors++; $display("FAIL b2b_done2 got %b exp 10", {a_cdone, a_tmo});
    end
    tick();
    $display("back-to-back commands done");
  endtask

  task automatic test_reset_mid_write();
    logic ok;
    a_valid = 1'b1; a_dw0 = 32'h0B0C_0018; a_dw1 = 32'h0403_0201;
    tick();
    a_valid = 1'b0;
    repeat (5) tick();  // N+5: byte 3
    checks++;
    if (a_wr !== 1'b1 || a_addr !== 12'd1003 || a_cfg !== 8'h0B) begin
      errors++; $display("FAIL rst_byte3 got wr=%b %0d:%h exp 1 1003:0b", a_wr, a_addr, a_cfg);
    end
    a_rst = 1'b1;
    tick();
    checks++;
    if ({a_mux, a_wr, a_en, a_busy, a_cdone, a_tmo, a_ready} !== 7'b0 || a_addr !== 12'd1000 || a_cfg !== 8'h00) begin
      errors++;
      $display("FAIL rst_abort got %b %0d:%h exp 0000000 1000:00",
               {a_mux, a_wr, a_en, a_busy, a_cdone, a_tmo, a_ready}, a_addr, a_cfg);
    end
    a_rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_wr !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rst_quiet got ok=%b exp 1", ok); end
    $display("reset during write done");
  endtask

  task automatic test_wrap_done_ignored();
    b_valid = 1'b1; b_dw0 = 32'h4433_2211; b_dw1 = 32'h8877_6655;
    tick();
    b_valid = 1'b0;
    tick();  // SEL_CFG
    checks++;
    if ({b_mux, b_wr} !== 2'b10) begin errors++; $display("FAIL wrap_selcfg got %b exp 10", {b_mux, b_wr}); end
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (b_wr !== 1'b1 || b_cdone !== 1'b0 || b_addr !== WRAP[k] || b_cfg !== EXP3[k]) begin
        errors++;
        $display("FAIL wrap_byte%0d got wr=%b done=%b %0d:%h exp 1 0 %0d:%h",
                 k, b_wr, b_cdone, b_addr, b_cfg, WRAP[k], EXP3[k]);
      end
      tick();
    end
    $display("wrapped write burst done");
  endtask

  task automatic test_timeout();
    logic ok;
    checks++;
    if ({b_mux, b_wr, b_en} !== 3'b000) begin errors++; $display("FAIL tmo_seldsn got %b exp 000", {b_mux, b_wr, b_en}); end
    tick();  // LAUNCH
    checks++;
    if (b_en !== 1'b1) begin errors++; $display("FAIL tmo_launch got en=%b exp 1", b_en); end
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (b_en !== 1'b1 || b_cdone !== 1'b0 || b_tmo !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL tmo_wait got ok=%b exp 1", ok); end
    tick();
    checks++;
    if ({b_cdone, b_tmo, b_en, b_busy} !== 4'b1101) begin
      errors++; $display("FAIL tmo_expire got %b exp 1101", {b_cdone, b_tmo, b_en, b_busy});
    end
    tick();
    checks++;
    if ({b_cdone, b_tmo, b_en, b_busy} !== 4'b0000) begin
      errors++; $display("FAIL tmo_idle got %b exp 0000", {b_cdone, b_tmo, b_en, b_busy});
    end
    $display("timeout command done");
  endtask

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_done = 1'b0; a_dw0 = '0; a_dw1 = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_done = 1'b0; b_dw0 = '0; b_dw1 = '0;
    #1;
    test_reset();
    test_write_burst();
    test_done();
    test_back_to_back();
    test_reset_mid_write();
    test_wrap_done_ignored();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
